// File: rtl/framebuf_scan_reader.sv
// -----------------------------------------------------------------------------
// framebuf_scan_reader
//
// Purpose:
//   Read-side master for the second port of the dual-port frame-buffer RAM.
//   Scans one frame of words in ascending address order and presents them as a
//   valid/ready stream to the LED shift driver. The RAM has a fixed one-cycle
//   read latency and cannot be stalled. A credit-limited skid FIFO therefore
//   absorbs sink backpressure: a read is only issued when the FIFO has room for
//   it.
//
// Ports:
//   clk, reset_n      system clock, synchronous active-low reset
//   start             1-cycle pulse, begins a frame scan (ignored while busy)
//   continuous        sampled at frame end, 1 = restart immediately
//   abort             1-cycle pulse, cancels the frame and flushes the FIFO
//   mem_address       RAM word address
//   mem_chipselect    RAM read strobe (data returns the following cycle)
//   mem_write         tied 0
//   mem_byteenable    tied all-ones
//   mem_readdata      RAM read data
//   st_data/st_valid/st_ready/st_sop/st_eop   output stream (FIFO head)
//   busy              scan in progress (RUN or DRAIN)
//   frame_done        1-cycle pulse in the cycle after the EOP word is accepted
//   active_bank       bank being scanned
//   bank_swap         1-cycle pulse when active_bank toggles (double-buffer only)
//
// Configuration:
//   FRAMEBUF_SCAN_DOUBLE_BUF_EN - when defined, the RAM is split into two banks
//   selected by the address MSB. The bank toggles after every completed frame
//   and the bank_swap port is added. When undefined, active_bank is 0 and the
//   full address range is used.
// -----------------------------------------------------------------------------
module framebuf_scan_reader #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FRAME_WORDS = 16384,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
  output logic                st_eop,
  output logic                busy,
  output logic                frame_done,
`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
  output logic                bank_swap,
`endif
  output logic                active_bank
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam addr_t LAST_OFF = addr_t'(FRAME_WORDS - 1);
  localparam cnt_t  DEPTH_C  = cnt_t'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           r_state;
  addr_t            r_offset;
  logic             r_inflight;
  logic             r_inflight_sop;
  logic             r_inflight_eop;
  cnt_t             r_count;
  ptr_t             r_wr_ptr;
  ptr_t             r_rd_ptr;
  logic             r_frame_done;
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_sop;
  logic [FIFO_DEPTH-1:0] r_fifo_eop;
`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
  logic             r_bank;
  logic             r_bank_swap;
`endif

  logic w_issue;
  logic w_last_issue;
  logic w_valid;
  logic w_pop;
  logic w_frame_end;

  // Credit check: entries already in the FIFO plus the read whose data is
  // still on its way must leave room for one more word.
  assign w_issue      = (r_state == S_RUN) && ((r_count + cnt_t'(r_inflight)) < DEPTH_C);
  assign w_last_issue = w_issue && (r_offset == LAST_OFF);
  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid && st_ready;
  // The EOP word is the last one issued, so its handshake also means the read
  // pipeline and the FIFO are empty.
  assign w_frame_end  = w_pop && r_fifo_eop[r_rd_ptr];

  assign mem_chipselect = w_issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign busy           = (r_state != S_IDLE);
  assign frame_done     = r_frame_done;

  assign st_valid = w_valid;
  assign st_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign st_sop   = w_valid && r_fifo_sop[r_rd_ptr];
  assign st_eop   = w_valid && r_fifo_eop[r_rd_ptr];

`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
  assign mem_address = {r_bank, r_offset[ADDR_W-2:0]};
  assign active_bank = r_bank;
  assign bank_swap   = r_bank_swap;
`else
  assign mem_address = r_offset;
  assign active_bank = 1'b0;
`endif

  // NOTE: every register in a clocked block is updated with <= so all of them
  // see the pre-edge values of each other, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_offset       <= '0;
      r_inflight     <= 1'b0;
      r_inflight_sop <= 1'b0;
      r_inflight_eop <= 1'b0;
      r_count        <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_frame_done   <= 1'b0;
`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
      r_bank         <= 1'b0;
      r_bank_swap    <= 1'b0;
`endif
    end else if (abort) begin
      // A read issued this cycle or last cycle is dropped with the flush.
      r_state      <= S_IDLE;
      r_offset     <= '0;
      r_inflight   <= 1'b0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_frame_done <= 1'b0;
`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
      r_bank_swap  <= 1'b0;
`endif
    end else begin
      r_frame_done   <= 1'b0;
`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
      r_bank_swap    <= 1'b0;
`endif
      r_inflight     <= w_issue;
      r_inflight_sop <= (r_offset == '0);
      r_inflight_eop <= (r_offset == LAST_OFF);

      // Terminal offset returns to 0 so the counter never depends on wrap.
      if (w_issue) r_offset <= w_last_issue ? '0 : r_offset + addr_t'(1);

      if (r_inflight) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      if (r_inflight && !w_pop)      r_count <= r_count + cnt_t'(1);
      else if (!r_inflight && w_pop) r_count <= r_count - cnt_t'(1);

      case (r_state)
        S_IDLE:  if (start) r_state <= S_RUN;
        S_RUN:   if (w_last_issue) r_state <= S_DRAIN;
        S_DRAIN: begin
          if (w_frame_end) begin
            r_state      <= continuous ? S_RUN : S_IDLE;
            r_frame_done <= 1'b1;
`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
            r_bank       <= ~r_bank;
            r_bank_swap  <= 1'b1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; r_count gates every read of it, so
  // stale contents are never visible and the array can map onto plain flops
  // or distributed RAM without a reset network.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_fifo_data[r_wr_ptr] <= mem_readdata;
      r_fifo_sop[r_wr_ptr]  <= r_inflight_sop;
      r_fifo_eop[r_wr_ptr]  <= r_inflight_eop;
    end
  end

endmodule

// File: tb/tb_framebuf_scan_reader.sv
// -----------------------------------------------------------------------------
// tb_framebuf_scan_reader
//
// Bench for framebuf_scan_reader with FRAME_WORDS=8, FIFO_DEPTH=4. A RAM model
// returns 16'hA000 + address one cycle after each read strobe. A reference
// model tracks reads as a queue of issued words and predicts every output on
// every cycle; directed sections pin the model with literal expectations,
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_framebuf_scan_reader;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int FW     = 8;
  localparam int DEPTH  = 4;
`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              continuous;
  logic              abort;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [1:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_sop;
  logic              st_eop;
  logic              busy;
  logic              frame_done;
  logic              active_bank;
`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
  logic              bank_swap;
`endif

  framebuf_scan_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .abort(abort), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop), .busy(busy),
    .frame_done(frame_done),
`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
    .bank_swap(bank_swap),
`endif
    .active_bank(active_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM port 2: word i holds 16'hA000 + i, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= 16'hA000 + 16'(mem_address);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of issued reads (address, frame offset, issue
  // cycle). A word becomes visible two cycles after its read is issued and
  // leaves the queue when accepted. Reads may issue while the number of
  // outstanding words is below the FIFO depth.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                off;
    int                cyc;
  } rd_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    int                cyc;
  } word_t;

  rd_t   q[$];
  word_t acc[$];
  int    cyc = 0;
  int    n_done = 0;
  int    n_cs = 0;
  int    n_swap = 0;

  initial begin : compare
    bit                m_busy, m_issue_done, m_done, m_bank;
    bit                exp_cs, exp_valid, nb_busy, nb_done, nb_bank;
    int                m_next_off;
    rd_t               h;
    logic [ADDR_W-1:0] off_v, exp_addr;
    m_busy = 0; m_issue_done = 1; m_done = 0; m_bank = 0; m_next_off = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        q.delete();
        m_busy = 0; m_issue_done = 1; m_done = 0; m_bank = 0; m_next_off = 0;
      end else begin
        exp_cs    = m_busy && !m_issue_done && (q.size() < DEPTH);
        exp_valid = (q.size() > 0) && (q[0].cyc <= cyc - 2);
        off_v     = ADDR_W'(m_next_off);
        exp_addr  = DBL ? {m_bank, off_v[ADDR_W-2:0]} : off_v;

        check("busy", busy, m_busy);
        check("frame_done", frame_done, m_done);
        check("active_bank", active_bank, m_bank);
        check("mem_chipselect", mem_chipselect, exp_cs);
        check("mem_write", mem_write, 0);
        check("mem_byteenable", mem_byteenable, 2'b11);
`ifdef FRAMEBUF_SCAN_DOUBLE_BUF_EN
        check("bank_swap", bank_swap, m_done);
        if (bank_swap) n_swap++;
`endif
        if (exp_cs && mem_chipselect) check("mem_address", mem_address, exp_addr);
        check("st_valid", st_valid, exp_valid);
        if (exp_valid && st_valid) begin
          check("st_data", st_data, 16'hA000 + 16'(q[0].addr));
          check("st_sop", st_sop, q[0].off == 0);
          check("st_eop", st_eop, q[0].off == FW - 1);
        end

        if (mem_chipselect) n_cs++;
        if (frame_done) n_done++;
        if (st_valid && st_ready) acc.push_back('{data: st_data, sop: st_sop, eop: st_eop, cyc: cyc});

        nb_busy = m_busy; nb_done = 0; nb_bank = m_bank;
        if (exp_cs) begin
          q.push_back('{addr: exp_addr, off: m_next_off, cyc: cyc});
          if (m_next_off == FW - 1) begin
            m_next_off = 0;
            m_issue_done = 1;
          end else begin
            m_next_off++;
          end
        end
        if (exp_valid && st_ready) begin
          h = q.pop_front();
          if (h.off == FW - 1) begin
            nb_done = 1;
            nb_busy = continuous;
            if (continuous) m_issue_done = 0;
            if (DBL) nb_bank = !m_bank;
          end
        end
        if (start && !m_busy) begin
          nb_busy = 1; m_issue_done = 0; m_next_off = 0;
        end
        if (abort) begin
          q.delete();
          nb_busy = 0; nb_done = 0; nb_bank = m_bank;
          m_next_off = 0; m_issue_done = 1;
        end
        m_busy = nb_busy; m_done = nb_done; m_bank = nb_bank;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int i;
    i = 0;
    while (n_done < target && i < budget) begin
      tick();
      i++;
    end
    check("frame_done_timeout", n_done >= target, 1);
  endtask

  task automatic check_frame(input string name, input int b);
    check({name, "_count"}, acc.size() - b, FW);
    for (int i = 0; i < FW && b + i < acc.size(); i++) begin
      check({name, "_data"}, acc[b+i].data, 16'hA000 + 16'(i));
      check({name, "_sop"}, acc[b+i].sop, i == 0);
      check({name, "_eop"}, acc[b+i].eop, i == FW - 1);
    end
  endtask

  initial begin
    int b, d0, c0, s0, i;
    bit found;
    reset_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; st_ready = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_st_valid", st_valid, 0);
    check("reset_chipselect", mem_chipselect, 0);
    check("reset_frame_done", frame_done, 0);

    // Single frame, sink always ready: eight words on consecutive cycles.
    st_ready = 1'b1;
    b = acc.size(); d0 = n_done;
    pulse_start();
    wait_done(d0 + 1, 100);
    check_frame("t1", b);
    if (acc.size() - b >= FW) check("t1_consecutive", acc[b+FW-1].cyc - acc[b].cyc, FW - 1);
    check("t1_done_count", n_done - d0, 1);
    check("t1_busy_after", busy, 0);

    // Sink stalled for 20 cycles: the credit limit caps reads at the FIFO depth.
    st_ready = 1'b0;
    b = acc.size(); d0 = n_done; c0 = n_cs;
    pulse_start();
    repeat (20) tick();
    check("t2_reads_stalled", n_cs - c0, DEPTH);
    check("t2_valid_held", st_valid, 1);
    check("t2_head_data", st_data, 16'hA000);
    check("t2_head_sop", st_sop, 1);
    st_ready = 1'b1;
    wait_done(d0 + 1, 100);
    check_frame("t2", b);

    // Abort on the third accepted word, then a fresh frame.
    st_ready = 1'b1;
    pulse_start();
    found = 0; i = 0;
    while (!found && i < 40) begin
      if (st_valid && st_data == 16'hA002) found = 1;
      else begin
        tick();
        i++;
      end
    end
    check("t4_third_word_seen", found, 1);
    d0 = n_done;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_valid_after_abort", st_valid, 0);
    check("t4_busy_after_abort", busy, 0);
    repeat (5) tick();
    check("t4_no_frame_done", n_done - d0, 0);
    b = acc.size();
    pulse_start();
    wait_done(d0 + 1, 100);
    check_frame("t4_restart", b);

    // Start while busy is ignored: still one frame of eight words.
    b = acc.size(); d0 = n_done;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_done(d0 + 1, 100);
    repeat (10) tick();
    check("t5_words_one_frame", acc.size() - b, FW);
    check("t5_one_done", n_done - d0, 1);

    // Reset in the middle of a frame.
    pulse_start();
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    check("rst_mem_address", mem_address, 0);
    check("rst_chipselect", mem_chipselect, 0);
    check("rst_st_data", st_data, 0);
    check("rst_st_valid", st_valid, 0);
    check("rst_st_sop", st_sop, 0);
    check("rst_st_eop", st_eop, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_active_bank", active_bank, 0);
    check("rst_byteenable", mem_byteenable, 2'b11);
    reset_n = 1'b1;
    b = acc.size();
    repeat (20) tick();
    check("rst_no_words", acc.size() - b, 0);

    // Continuous mode with a toggling sink: three back-to-back frames.
    b = acc.size(); d0 = n_done; s0 = n_swap;
    continuous = 1'b1;
    pulse_start();
    i = 0;
    while (n_done - d0 < 3 && i < 400) begin
      st_ready = ~st_ready;
      if (n_done - d0 >= 2) continuous = 1'b0;
      tick();
      i++;
    end
    continuous = 1'b0;
    st_ready = 1'b1;
    check("t3_done_count", n_done - d0, 3);
    check("t3_word_count", acc.size() - b, 3 * FW);
    for (int k = 0; k < 3 * FW && b + k < acc.size(); k++) begin
      check("t3_data", acc[b+k].data,
            16'hA000 + 16'(k % FW) + ((DBL && ((k / FW) % 2 == 1)) ? 16'h2000 : 16'h0000));
      check("t3_sop", acc[b+k].sop, (k % FW) == 0);
      check("t3_eop", acc[b+k].eop, (k % FW) == FW - 1);
    end
    if (DBL) check("t3_bank_swaps", n_swap - s0, 3);
    repeat (3) tick();
    check("t3_idle_after", busy, 0);

    // Randomized phase, checked cycle by cycle by the model.
    for (int n = 0; n < 600; n++) begin
      continuous = 1'($urandom_range(0, 1));
      st_ready   = ($urandom_range(0, 3) != 0);
      start      = ($urandom_range(0, 15) == 0);
      abort      = ($urandom_range(0, 59) == 0);
      reset_n    = ($urandom_range(0, 249) != 0);
      tick();
    end
    reset_n = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; st_ready = 1'b1;
    i = 0;
    while (busy && i < 100) begin
      tick();
      i++;
    end
    check("final_idle", busy, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
